instr_ram_port_arb: RTL and testbench
=====================================

# instr_ram_port_arb

Two-port front end for the instruction memory: arbitrates between the core instruction-fetch port (read-only) and the external load/debug port (read/write, fed by the bus bridge), drives the single-port `instr_ram_wrap` interface, and returns read data with its one-cycle latency to the port that issued the access. Core fetch has priority. A saturating starvation counter guarantees that the external port makes progress.

## Interface
Parameters:
- `ADDR_WIDTH`, 16: byte address width including the boot-ROM select MSB; matches the RAM wrapper.
- `DATA_WIDTH`, 32: data width; the byte-enable width is `DATA_WIDTH/8`.
- `STARVE_MAX`, 4: number of consecutive cycles the external request may be refused before it must win.

Ports:
- `clk`  in  1: clock.
- `rst_n`  in  1: reset, asynchronous, active-low.
- `core_req_i`  in  1: core fetch request.
- `core_addr_i`  in  `ADDR_WIDTH`: core fetch address.
- `core_gnt_o`  out  1: core request accepted this cycle.
- `core_rvalid_o`  out  1: core read data valid.
- `core_rdata_o`  out  `DATA_WIDTH`: core read data.
- `ext_req_i`  in  1: external request.
- `ext_we_i`  in  1: external write enable.
- `ext_be_i`  in  `DATA_WIDTH/8`: external byte enables.
- `ext_addr_i`  in  `ADDR_WIDTH`: external address.
- `ext_wdata_i`  in  `DATA_WIDTH`: external write data.
- `ext_gnt_o`  out  1: external request accepted this cycle.
- `ext_rvalid_o`  out  1: external response valid (reads and writes).
- `ext_rdata_o`  out  `DATA_WIDTH`: external read data.
- `mem_en_o`, `mem_addr_o`, `mem_wdata_o`, `mem_we_o`, `mem_be_o`  out: RAM wrapper request.
- `mem_rdata_i`  in  `DATA_WIDTH`: RAM wrapper read data, valid one cycle after `mem_en_o`.

## Operation
- Grant is combinational in the request cycle. At most one grant is asserted per cycle. `mem_en_o = core_gnt_o | ext_gnt_o`.
- Priority:
  - `ext_gnt_o = ext_req_i & (~core_req_i | starve_q == STARVE_MAX)`.
  - `core_gnt_o = core_req_i & ~ext_gnt_o`.
- Starvation counter `starve_q`:
  - Increments each cycle in which `ext_req_i & ~ext_gnt_o`, saturating at `STARVE_MAX`.
  - Clears to 0 on `ext_gnt_o` or when `ext_req_i` is low.
- Memory mux:
  - The granted port's address drives `mem_addr_o`.
  - `mem_we_o = ext_gnt_o & ext_we_i & ~ext_addr_i[ADDR_WIDTH-1]`. Writes to the boot-ROM region are granted and acknowledged but never written.
  - `mem_wdata_o` and `mem_be_o` come from the external port. They are don't-care when the core is granted; `mem_be_o` is driven to all-ones in that case.
  - The core port never writes.
- Response owner register `owner_q`:
  - Values: `OWN_NONE`, `OWN_CORE`, `OWN_EXT`.
  - Loaded each cycle from the grant: `OWN_CORE` if `core_gnt_o`, `OWN_EXT` if `ext_gnt_o`, otherwise `OWN_NONE`.
  - `core_rvalid_o = (owner_q == OWN_CORE)`.
  - `ext_rvalid_o = (owner_q == OWN_EXT)`.
- Read data:
  - `core_rdata_o` and `ext_rdata_o` equal `mem_rdata_i` when their rvalid is high, else 0.
  - For an external write, `ext_rdata_o` is 0.
- Back-to-back accesses are supported every cycle on either port, including alternating owners.

## Timing
- Reset values: `owner_q = OWN_NONE`, `starve_q = 0`, both rvalid outputs 0, both rdata outputs 0.
- Grant and `mem_*` outputs are combinational and therefore 0 whenever no request is present.
- Latency: grant in cycle N, rvalid and rdata in cycle N+1. Throughput is one access per cycle.
- Worst-case external wait under continuous core fetch: `STARVE_MAX` refused cycles, then granted in the next cycle.
- A requester holds its request and address stable until granted. Dropping a request before grant is legal; the counter clears.
- Simultaneous requests with `starve_q < STARVE_MAX`: core is granted, the counter increments.
- Simultaneous requests with `starve_q == STARVE_MAX`: external is granted, the counter clears, the core waits one cycle.
- Reset asserted mid-operation: any pending response is dropped. No rvalid is issued after reset release for an access granted before reset.

## Structure
- Put the `owner_e` typedef (2-bit: `OWN_NONE=0`, `OWN_CORE=1`, `OWN_EXT=2`) in the shared `RISCV_MCU_CONFIG` package.
- Put a default `STARVE_MAX` constant in the same package.
- One sub-module: `starve_counter`, a saturating up-counter with clear, parameterized by its maximum, exposing `count_o` and `sat_o`.
- Top-level ports connect one-to-one to `instr_ram_wrap` (`en`, `addr`, `wdata`, `we`, `be`, `rdata`).

## Test plan
- Core-only fetches at 0x0000, 0x0004, 0x0008, back-to-back -> `core_gnt_o` high each cycle; `core_rvalid_o` one cycle later with the matching RAM words; `ext_rvalid_o` stays 0.
- External write 0xDEADBEEF, be=4'b1111 to 0x0010, then external read of 0x0010 -> `mem_we_o` high for the write; `ext_rvalid_o` for both; the read returns 0xDEADBEEF.
- Continuous `core_req_i` plus `ext_req_i` held, `STARVE_MAX=4` -> external refused 4 cycles, granted on the 5th; core refused that cycle and granted the next.
- External write with the address MSB set (0x8000) -> `ext_gnt_o` and `ext_rvalid_o` asserted, `mem_we_o` 0; ROM contents unchanged.
- Alternating core and external grants every cycle -> each rvalid asserted only on its owner's response cycle; rdata routed without swap.
- `rst_n` pulsed low the cycle after a core grant -> no `core_rvalid_o` after release; `owner_q` is `OWN_NONE` and `starve_q` is 0.

Source files
------------

// File: rtl/instr_ram_port_arb_pkg.sv
// rtl/instr_ram_port_arb_pkg.sv - shared MCU configuration: response owner encoding and arbiter defaults
//
// Contents:
//   owner_e            - which port owns the read response in the next cycle
//   STARVE_MAX_DEFAULT - default refusal budget for the external port
//   owner_from_grant   - maps the one-hot grant pair onto owner_e
package RISCV_MCU_CONFIG;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CORE = 2'd1,
    OWN_EXT  = 2'd2
  } owner_e;

  localparam int STARVE_MAX_DEFAULT = 4;

  // Grants are mutually exclusive, so the order of the tests does not matter.
  function automatic owner_e owner_from_grant(input logic core_gnt, input logic ext_gnt);
    if (core_gnt) return OWN_CORE;
    if (ext_gnt)  return OWN_EXT;
    return OWN_NONE;
  endfunction

endpackage

// File: rtl/instr_ram_port_arb_if.sv
// rtl/instr_ram_port_arb_if.sv - core fetch, external load/debug and RAM wrapper bus bundle
//
// Signals:
//   core_*  - core fetch port (read-only): req/addr in, gnt/rvalid/rdata out
//   ext_*   - external port (read/write): req/we/be/addr/wdata in, gnt/rvalid/rdata out
//   mem_*   - single-port instr_ram_wrap request, mem_rdata_i one cycle after mem_en_o
// Modports:
//   slave   - the arbiter
//   master  - requesters plus RAM wrapper (environment side)
interface instr_ram_port_arb_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);

  logic                    core_req_i;
  logic [ADDR_WIDTH-1:0]   core_addr_i;
  logic                    core_gnt_o;
  logic                    core_rvalid_o;
  logic [DATA_WIDTH-1:0]   core_rdata_o;

  logic                    ext_req_i;
  logic                    ext_we_i;
  logic [DATA_WIDTH/8-1:0] ext_be_i;
  logic [ADDR_WIDTH-1:0]   ext_addr_i;
  logic [DATA_WIDTH-1:0]   ext_wdata_i;
  logic                    ext_gnt_o;
  logic                    ext_rvalid_o;
  logic [DATA_WIDTH-1:0]   ext_rdata_o;

  logic                    mem_en_o;
  logic [ADDR_WIDTH-1:0]   mem_addr_o;
  logic [DATA_WIDTH-1:0]   mem_wdata_o;
  logic                    mem_we_o;
  logic [DATA_WIDTH/8-1:0] mem_be_o;
  logic [DATA_WIDTH-1:0]   mem_rdata_i;

  modport slave (
    input  core_req_i, core_addr_i,
    output core_gnt_o, core_rvalid_o, core_rdata_o,
    input  ext_req_i, ext_we_i, ext_be_i, ext_addr_i, ext_wdata_i,
    output ext_gnt_o, ext_rvalid_o, ext_rdata_o,
    output mem_en_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_be_o,
    input  mem_rdata_i
  );

  modport master (
    output core_req_i, core_addr_i,
    input  core_gnt_o, core_rvalid_o, core_rdata_o,
    output ext_req_i, ext_we_i, ext_be_i, ext_addr_i, ext_wdata_i,
    input  ext_gnt_o, ext_rvalid_o, ext_rdata_o,
    input  mem_en_o, mem_addr_o, mem_wdata_o, mem_we_o, mem_be_o,
    output mem_rdata_i
  );

endinterface

// File: rtl/instr_ram_port_arb_starve_counter.sv
// rtl/instr_ram_port_arb_starve_counter.sv - saturating up-counter with synchronous clear
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   inc        - count up by one, holding at MAX
//   clr        - return to zero (wins over inc)
//   count_o    - current count
//   sat_o      - count_o == MAX
module starve_counter #(
  parameter int MAX = 4,
  parameter int CW  = $clog2(MAX + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          inc,
  input  logic          clr,
  output logic [CW-1:0] count_o,
  output logic          sat_o
);

  logic [CW-1:0] count_q;

  assign sat_o   = (count_q == CW'(MAX));
  assign count_o = count_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && !sat_o) begin
      count_q <= count_q + CW'(1);
    end
  end

endmodule

// File: rtl/instr_ram_port_arb.sv
// rtl/instr_ram_port_arb.sv - core/external arbiter in front of the single-port instruction RAM
//
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - instr_ram_port_arb_if.slave: core fetch port, external
//                load/debug port and instr_ram_wrap request/response
// Core fetch wins unless the external port has already been refused
// STARVE_MAX cycles in a row. Read data returns one cycle after the grant
// and is steered to whichever port owned that grant.
module instr_ram_port_arb
  import RISCV_MCU_CONFIG::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst_n,
  instr_ram_port_arb_if.slave  bus
);

  localparam int BE_WIDTH = DATA_WIDTH / 8;
  localparam int CW       = $clog2(STARVE_MAX + 1);

  logic          core_gnt;
  logic          ext_gnt;
  logic          starve_sat;
  logic [CW-1:0] starve_q;
  owner_e        owner_q;
  logic          ext_wr_q;   // external response belongs to a write: data is zero

  // ---------------------------------------------------------------------------
  // Grant
  // ---------------------------------------------------------------------------
  assign ext_gnt  = bus.ext_req_i & (~bus.core_req_i | starve_sat);
  assign core_gnt = bus.core_req_i & ~ext_gnt;

  assign bus.core_gnt_o = core_gnt;
  assign bus.ext_gnt_o  = ext_gnt;

  // Clearing on a low request means a dropped request starts a fresh budget.
  starve_counter #(
    .MAX (STARVE_MAX),
    .CW  (CW)
  ) u_starve (
    .clk     (clk),
    .rst_n   (rst_n),
    .inc     (bus.ext_req_i & ~ext_gnt),
    .clr     (ext_gnt | ~bus.ext_req_i),
    .count_o (starve_q),
    .sat_o   (starve_sat)
  );

  // ---------------------------------------------------------------------------
  // Memory request mux
  // ---------------------------------------------------------------------------
  always_comb begin
    bus.mem_en_o    = core_gnt | ext_gnt;
    bus.mem_addr_o  = '0;
    bus.mem_wdata_o = '0;
    bus.mem_we_o    = 1'b0;
    bus.mem_be_o    = '0;
    if (ext_gnt) begin
      bus.mem_addr_o  = bus.ext_addr_i;
      bus.mem_wdata_o = bus.ext_wdata_i;
      // Boot-ROM region: the access is granted and acknowledged, never written.
      bus.mem_we_o    = bus.ext_we_i & ~bus.ext_addr_i[ADDR_WIDTH-1];
      bus.mem_be_o    = bus.ext_be_i;
    end else if (core_gnt) begin
      bus.mem_addr_o  = bus.core_addr_i;
      bus.mem_be_o    = {BE_WIDTH{1'b1}};
    end
  end

  // ---------------------------------------------------------------------------
  // Response ownership
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q  <= OWN_NONE;
      ext_wr_q <= 1'b0;
    end else begin
      owner_q  <= owner_from_grant(core_gnt, ext_gnt);
      ext_wr_q <= ext_gnt & bus.ext_we_i;
    end
  end

  assign bus.core_rvalid_o = (owner_q == OWN_CORE);
  assign bus.ext_rvalid_o  = (owner_q == OWN_EXT);

  assign bus.core_rdata_o = bus.core_rvalid_o ? bus.mem_rdata_i : '0;
  assign bus.ext_rdata_o  = (bus.ext_rvalid_o && !ext_wr_q) ? bus.mem_rdata_i : '0;

endmodule

// File: tb/tb_instr_ram_port_arb.sv
// tb/tb_instr_ram_port_arb.sv - directed self-checking bench for instr_ram_port_arb
module tb_instr_ram_port_arb;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_bad;

  instr_ram_port_arb_if #(.ADDR_WIDTH(16), .DATA_WIDTH(32)) bus ();

  instr_ram_port_arb #(
    .ADDR_WIDTH (16),
    .DATA_WIDTH (32),
    .STARVE_MAX (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // RAM wrapper stand-in: unwritten words read back as a recognisable pattern,
  // ROM half (addr[15]) as B00D_xxxx, RAM half as 1000_xxxx.
  logic [31:0] mem_words [128];
  bit   [127:0] written;

  function automatic logic [31:0] dflt(input logic [15:0] a);
    return a[15] ? {16'hB00D, a} : {16'h1000, a};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old_w;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  always @(posedge clk) begin
    if (bus.mem_en_o) begin
      if (bus.mem_we_o) begin
        mem_words[{bus.mem_addr_o[15], bus.mem_addr_o[7:2]}] <= merge(
          written[{bus.mem_addr_o[15], bus.mem_addr_o[7:2]}] ?
            mem_words[{bus.mem_addr_o[15], bus.mem_addr_o[7:2]}] : dflt(bus.mem_addr_o),
          bus.mem_wdata_o, bus.mem_be_o);
        written[{bus.mem_addr_o[15], bus.mem_addr_o[7:2]}] <= 1'b1;
      end
      bus.mem_rdata_i <= written[{bus.mem_addr_o[15], bus.mem_addr_o[7:2]}] ?
                         mem_words[{bus.mem_addr_o[15], bus.mem_addr_o[7:2]}] :
                         dflt(bus.mem_addr_o);
    end
  end

  task automatic expect_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.core_req_i  = 1'b0;
    bus.core_addr_i = '0;
    bus.ext_req_i   = 1'b0;
    bus.ext_we_i    = 1'b0;
    bus.ext_be_i    = '0;
    bus.ext_addr_i  = '0;
    bus.ext_wdata_i = '0;
  endtask

  task automatic ext_drive(input logic we, input logic [15:0] a, input logic [31:0] d);
    bus.ext_req_i   = 1'b1;
    bus.ext_we_i    = we;
    bus.ext_be_i    = 4'hF;
    bus.ext_addr_i  = a;
    bus.ext_wdata_i = d;
  endtask

  logic [15:0] alt_addr [4];
  logic [31:0] alt_data [4];

  initial begin
    n_cmp = 0;
    n_bad = 0;
    bus.mem_rdata_i = '0;
    idle_inputs();
    rst_n = 1'b0;
    #12;

    // Reset state
    expect_eq("rst_core_rvalid", 32'(bus.core_rvalid_o), 32'd0);
    expect_eq("rst_ext_rvalid",  32'(bus.ext_rvalid_o),  32'd0);
    expect_eq("rst_core_rdata",  bus.core_rdata_o,       32'd0);
    expect_eq("rst_ext_rdata",   bus.ext_rdata_o,        32'd0);
    expect_eq("rst_mem_en",      32'(bus.mem_en_o),      32'd0);
    expect_eq("rst_owner",       32'(dut.owner_q),       32'd0);
    expect_eq("rst_starve",      32'(dut.starve_q),      32'd0);

    cyc();
    rst_n = 1'b1;
    cyc();
    expect_eq("idle_mem_en", 32'(bus.mem_en_o), 32'd0);

    // Core-only back-to-back fetches at 0x0, 0x4, 0x8
    for (int i = 0; i < 4; i++) begin
      if (i < 3) begin
        bus.core_req_i  = 1'b1;
        bus.core_addr_i = 16'(4 * i);
      end else begin
        bus.core_req_i = 1'b0;
      end
      #1;
      if (i > 0) begin
        expect_eq("core_rvalid", 32'(bus.core_rvalid_o), 32'd1);
        expect_eq("core_rdata",  bus.core_rdata_o, 32'h1000_0000 + 32'(4 * (i - 1)));
      end
      expect_eq("core_ext_rvalid", 32'(bus.ext_rvalid_o), 32'd0);
      if (i < 3) begin
        expect_eq("core_gnt",    32'(bus.core_gnt_o), 32'd1);
        expect_eq("core_maddr",  32'(bus.mem_addr_o), 32'(4 * i));
        expect_eq("core_mbe",    32'(bus.mem_be_o),   32'hF);
        expect_eq("core_mwe",    32'(bus.mem_we_o),   32'd0);
      end
      cyc();
    end
    expect_eq("core_rvalid_end", 32'(bus.core_rvalid_o), 32'd0);

    // External write then read of 0x0010
    ext_drive(1'b1, 16'h0010, 32'hDEAD_BEEF);
    #1;
    expect_eq("extw_gnt",   32'(bus.ext_gnt_o),  32'd1);
    expect_eq("extw_mwe",   32'(bus.mem_we_o),   32'd1);
    expect_eq("extw_wdata", bus.mem_wdata_o,     32'hDEAD_BEEF);
    cyc();
    ext_drive(1'b0, 16'h0010, 32'h0);
    #1;
    expect_eq("extw_rvalid", 32'(bus.ext_rvalid_o), 32'd1);
    expect_eq("extw_rdata",  bus.ext_rdata_o,       32'd0);
    expect_eq("extr_mwe",    32'(bus.mem_we_o),     32'd0);
    cyc();
    idle_inputs();
    #1;
    expect_eq("extr_rvalid", 32'(bus.ext_rvalid_o), 32'd1);
    expect_eq("extr_rdata",  bus.ext_rdata_o,       32'hDEAD_BEEF);
    expect_eq("extr_core_rvalid", 32'(bus.core_rvalid_o), 32'd0);
    cyc();

    // Starvation: core fetching continuously, external read of 0x0010 held
    for (int k = 0; k < 7; k++) begin
      bus.core_req_i  = (k < 6);
      bus.core_addr_i = 16'h0020;
      if (k < 5) ext_drive(1'b0, 16'h0010, 32'h0);
      else       bus.ext_req_i = 1'b0;
      #1;
      if (k < 5) begin
        expect_eq($sformatf("stv_ext_gnt_%0d", k),  32'(bus.ext_gnt_o),  32'(k == 4));
        expect_eq($sformatf("stv_count_%0d", k),    32'(dut.starve_q),   32'(k));
      end
      if (k < 6)
        expect_eq($sformatf("stv_core_gnt_%0d", k), 32'(bus.core_gnt_o), 32'(k != 4));
      if (k == 5) begin
        expect_eq("stv_ext_rvalid",  32'(bus.ext_rvalid_o),  32'd1);
        expect_eq("stv_ext_rdata",   bus.ext_rdata_o,        32'hDEAD_BEEF);
        expect_eq("stv_core_rvalid", 32'(bus.core_rvalid_o), 32'd0);
        expect_eq("stv_count_clr",   32'(dut.starve_q),      32'd0);
      end
      if (k == 1 || k == 6) begin
        expect_eq("stv_core_rvalid1", 32'(bus.core_rvalid_o), 32'd1);
        expect_eq("stv_core_rdata",   bus.core_rdata_o,       32'h1000_0020);
      end
      cyc();
    end
    idle_inputs();
    cyc();

    // Write to boot-ROM region is acknowledged but not performed
    ext_drive(1'b1, 16'h8000, 32'h1234_5678);
    #1;
    expect_eq("rom_gnt",    32'(bus.ext_gnt_o), 32'd1);
    expect_eq("rom_mem_en", 32'(bus.mem_en_o),  32'd1);
    expect_eq("rom_mwe",    32'(bus.mem_we_o),  32'd0);
    cyc();
    ext_drive(1'b0, 16'h8000, 32'h0);
    #1;
    expect_eq("rom_w_rvalid", 32'(bus.ext_rvalid_o), 32'd1);
    expect_eq("rom_w_rdata",  bus.ext_rdata_o,       32'd0);
    cyc();
    idle_inputs();
    #1;
    expect_eq("rom_r_rdata", bus.ext_rdata_o, 32'hB00D_8000);
    cyc();

    // Alternating owners every cycle: core 0x0C, ext 0x10, core 0x04, ext 0x14
    alt_addr[0] = 16'h000C; alt_data[0] = 32'h1000_000C;
    alt_addr[1] = 16'h0010; alt_data[1] = 32'hDEAD_BEEF;
    alt_addr[2] = 16'h0004; alt_data[2] = 32'h1000_0004;
    alt_addr[3] = 16'h0014; alt_data[3] = 32'h1000_0014;
    for (int j = 0; j < 5; j++) begin
      idle_inputs();
      if (j < 4) begin
        if (j % 2 == 0) begin
          bus.core_req_i  = 1'b1;
          bus.core_addr_i = alt_addr[j];
        end else begin
          ext_drive(1'b0, alt_addr[j], 32'h0);
        end
      end
      #1;
      if (j < 4) begin
        expect_eq($sformatf("alt_core_gnt_%0d", j), 32'(bus.core_gnt_o), 32'(j % 2 == 0));
        expect_eq($sformatf("alt_ext_gnt_%0d", j),  32'(bus.ext_gnt_o),  32'(j % 2 == 1));
      end
      if (j > 0) begin
        expect_eq($sformatf("alt_core_rv_%0d", j), 32'(bus.core_rvalid_o), 32'((j - 1) % 2 == 0));
        expect_eq($sformatf("alt_ext_rv_%0d", j),  32'(bus.ext_rvalid_o),  32'((j - 1) % 2 == 1));
        expect_eq($sformatf("alt_core_rd_%0d", j), bus.core_rdata_o,
                  ((j - 1) % 2 == 0) ? alt_data[j-1] : 32'd0);
        expect_eq($sformatf("alt_ext_rd_%0d", j),  bus.ext_rdata_o,
                  ((j - 1) % 2 == 1) ? alt_data[j-1] : 32'd0);
      end
      cyc();
    end

    // Reset the cycle after a core grant: pending response is dropped
    bus.core_req_i  = 1'b1;
    bus.core_addr_i = 16'h0008;
    ext_drive(1'b0, 16'h0010, 32'h0);
    #1;
    expect_eq("rsto_core_gnt", 32'(bus.core_gnt_o), 32'd1);
    cyc();
    idle_inputs();
    rst_n = 1'b0;
    #1;
    expect_eq("rsto_core_rvalid", 32'(bus.core_rvalid_o), 32'd0);
    expect_eq("rsto_owner",       32'(dut.owner_q),       32'd0);
    expect_eq("rsto_starve",      32'(dut.starve_q),      32'd0);
    cyc();
    rst_n = 1'b1;
    #1;
    expect_eq("rsto_rel_rvalid", 32'(bus.core_rvalid_o), 32'd0);
    cyc();
    expect_eq("rsto_rel_rvalid2", 32'(bus.core_rvalid_o), 32'd0);
    expect_eq("rsto_rel_rdata",   bus.core_rdata_o,       32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
